bnn_result_encoder: RTL and testbench
=====================================

Name: bnn_result_encoder

Overview:
Transmit-side counterpart to the BNN command decoder. It captures each 4-bit BNN classification result and frames it as a 4-byte response stream (header, payload, status, checksum). The stream goes to the SPI slave transmit path over a valid/ready byte handshake. It sits between the BNN_MLP output and the SPI TX shift register in the CW305 SPI build.

Parameters:
RESULT_W, 4, width of BNN result field (must be <= 4, zero-extended into the payload nibble)
HDR_BYTE, 8'hA5, constant frame header byte
SEQ_W, 4, width of frame sequence counter (occupies payload[7:4])

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
res_valid  input  1  single-cycle strobe: res_data is a new BNN result
res_data  input  RESULT_W  BNN result
tx_data  output  8  byte to SPI transmitter
tx_valid  output  1  tx_data is valid
tx_ready  input  1  SPI transmitter accepts byte this cycle when high with tx_valid
busy  output  1  FSM not in IDLE
pending  output  1  holding buffer occupied
overflow  output  1  sticky: a result has been dropped since the last accepted status byte

Behaviour:
- Reset (synchronous, active-high, overrides all): FSM=IDLE; tx_data=8'h00; tx_valid=0; busy=0; pending=0; overflow=0; seq=0; drop_cnt=0; holding buffer cleared. Reset mid-frame aborts the frame with no completion. tx_valid is low the cycle after rst is sampled.
- Holding buffer: 1 entry.
  - res_valid with buffer empty -> captures res_data; pending=1 next cycle.
  - res_valid with buffer full and not unloaded the same cycle -> result dropped; overflow=1; drop_cnt++ saturating at 15.
  - res_valid in the same cycle the FSM unloads the buffer -> new result captured, no drop.
- FSM states: IDLE, HDR, PAY, STAT, CSUM. A byte is accepted on a cycle with tx_valid && tx_ready.
  - IDLE: when pending, unload the buffer into the frame register. Next cycle: state=HDR, tx_data=HDR_BYTE, tx_valid=1. Latency is res_valid (cycle N, buffer empty, FSM idle) -> header presented at cycle N+2.
  - HDR accepted -> PAY: tx_data = {seq, result zero-extended}.
  - PAY accepted -> STAT: tx_data = {overflow, pending, 2'b00, drop_cnt}, sampled on the PAY-accept edge.
  - STAT accepted -> CSUM: tx_data = XOR of the three prior bytes. On that same edge, overflow and drop_cnt clear unless a drop occurs that same cycle; a same-cycle drop leaves overflow=1 and drop_cnt=1.
  - CSUM accepted: seq increments, wrapping (2^SEQ_W - 1) -> 0.
    - If pending, unload the buffer and go directly to HDR. No idle cycle; tx_valid stays high.
    - Otherwise go to IDLE with tx_valid=0.
- tx_data and tx_valid are registered and held stable while tx_valid && !tx_ready. No combinational path from tx_ready to tx_data or tx_valid.
- busy=1 in HDR/PAY/STAT/CSUM.
- Checksum is computed on registered byte values, never on live inputs.

Test Plan:
- Single frame: reset; tx_ready=1; res_valid with res_data=6 -> bytes A5, 06, 00, A3 on consecutive cycles; header appears 2 cycles after the strobe; busy drops after CSUM.
- Back-pressure: tx_ready=0 for 10 cycles, strobe 3, strobe 9, then tx_ready=1 -> A5 03 40 E6 then immediately A5 19 00 BC; tx_valid never drops between frames; tx_data stable during stall.
- Overflow: tx_ready=0; strobe 1, 2, 3; release -> A5 01 C1 65, then A5 12 00 B7; overflow cleared after the first status byte is accepted; result 3 never sent.
- Sequence wrap: 17 frames with results 0..15,0 -> payload high nibble runs 0..F then 0; every checksum correct.
- Random tx_ready toggling (50%) over 200 frames -> scoreboard matches all bytes; no byte duplicated or lost.
- Reset mid-frame: assert rst while in STAT with tx_ready=0 -> tx_valid=0 next cycle, all outputs at reset values; the next strobe of 5 yields A5 05 00 A0 (seq restarted at 0).

Source files
------------

// File: rtl/bnn_result_encoder.sv
// bnn_result_encoder: frames each BNN classification result as a 4-byte
// response (header, payload, status, checksum). The bytes go out over a
// valid/ready byte handshake toward the SPI slave transmit path.
module bnn_result_encoder #(
  parameter int          RESULT_W = 4,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter int          SEQ_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                res_valid,
  input  logic [RESULT_W-1:0] res_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                pending,
  output logic                overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_STAT,
    S_CSUM
  } state_t;

  state_t              r_state;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic [SEQ_W-1:0]    r_seq;
  logic [RESULT_W-1:0] r_res;
  logic [RESULT_W-1:0] r_buf;
  logic                r_full;
  logic                r_ovf;
  logic [3:0]          r_dcnt;

  logic                w_accept;
  logic                w_unload;
  logic                w_drop;
  logic                w_stat_clear;
  logic [7:0]          w_payload;

  // Handshake, buffer unload and drop decisions for this cycle
  always_comb begin
    w_accept     = r_tx_valid && tx_ready;
    w_unload     = r_full && ((r_state == S_IDLE) ||
                              ((r_state == S_CSUM) && w_accept));
    w_drop       = res_valid && r_full && !w_unload;
    w_stat_clear = (r_state == S_STAT) && w_accept;
    w_payload    = {4'(r_seq), 4'(r_res)};
  end

  // Frame FSM: walks the four bytes and owns the registered TX outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_seq      <= '0;
      r_res      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_unload) begin
            r_res      <= r_buf;
            r_state    <= S_HDR;
            r_tx_data  <= HDR_BYTE;
            r_tx_valid <= 1'b1;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_state   <= S_PAY;
            r_tx_data <= w_payload;
          end
        end
        S_PAY: begin
          if (w_accept) begin
            r_state   <= S_STAT;
            r_tx_data <= {r_ovf, r_full, 2'b00, r_dcnt};
          end
        end
        S_STAT: begin
          // r_tx_data still holds the status byte here, so the checksum
          // is built purely from registered values
          if (w_accept) begin
            r_state   <= S_CSUM;
            r_tx_data <= HDR_BYTE ^ w_payload ^ r_tx_data;
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            r_seq <= r_seq + 1'b1;
            if (w_unload) begin
              r_res     <= r_buf;
              r_state   <= S_HDR;
              r_tx_data <= HDR_BYTE;
            end else begin
              r_state    <= S_IDLE;
              r_tx_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  // One-entry holding buffer; a same-cycle unload frees the slot for a new capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_buf  <= '0;
    end else if (res_valid && (!r_full || w_unload)) begin
      r_buf  <= res_data;
      r_full <= 1'b1;
    end else if (w_unload) begin
      r_full <= 1'b0;
    end
  end

  // Sticky overflow and saturating drop count, cleared when the status byte is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_dcnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (w_stat_clear)
        r_dcnt <= 4'd1;
      else if (r_dcnt != 4'hF)
        r_dcnt <= r_dcnt + 4'd1;
    end else if (w_stat_clear) begin
      r_ovf  <= 1'b0;
      r_dcnt <= '0;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = (r_state != S_IDLE);
  assign pending  = r_full;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bnn_result_encoder.sv
// Testbench for bnn_result_encoder: table-driven frames, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_bnn_result_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       res_valid;
  logic [3:0] res_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       pending;
  logic       overflow;

  always #5 clk = ~clk;

  bnn_result_encoder #(
    .RESULT_W(4),
    .HDR_BYTE(8'hA5),
    .SEQ_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .res_valid(res_valid),
    .res_data(res_data),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .pending(pending),
    .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a result queue standing in for the holding buffer, the
  // current frame as a 4-byte array plus an index, and status counters.
  int         mq[$];
  bit         m_act;
  int         m_idx;
  logic [7:0] m_fb[4];
  logic [3:0] m_seq;
  logic [3:0] m_dcnt;
  bit         m_ovf;
  logic [3:0] m_res;
  bit         m_rst_prev;

  logic [7:0] got[$];

  typedef struct {
    logic [3:0] res;
    logic [7:0] pay;
    logic [7:0] stat;
    logic [7:0] csum;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit rv, input logic [3:0] rd, input bit rdy);
    bit had;
    bit acc;
    bit unl;
    bit drop;
    if (r) begin
      mq.delete();
      m_act  = 0;
      m_idx  = 0;
      m_seq  = 0;
      m_dcnt = 0;
      m_ovf  = 0;
      return;
    end
    had  = mq.size() > 0;
    acc  = m_act && rdy;
    unl  = had && (!m_act || (acc && m_idx == 3));
    drop = rv && had && !unl;
    if (acc) begin
      case (m_idx)
        0: begin m_fb[1] = {m_seq, m_res}; m_idx = 1; end
        1: begin m_fb[2] = {m_ovf, had, 2'b00, m_dcnt}; m_idx = 2; end
        2: begin
          m_fb[3] = m_fb[0] ^ m_fb[1] ^ m_fb[2];
          m_idx = 3;
          m_ovf = 0;
          m_dcnt = 0;
        end
        default: begin m_seq = m_seq + 4'd1; m_act = 0; end
      endcase
    end
    if (unl) begin
      m_res   = 4'(mq.pop_front());
      m_act   = 1;
      m_idx   = 0;
      m_fb[0] = 8'hA5;
    end
    if (drop) begin
      m_ovf = 1;
      if (m_dcnt != 4'hF) m_dcnt = m_dcnt + 4'd1;
    end else if (rv) begin
      mq.push_back(int'(rd));
    end
  endtask

  // One clock: record accepted byte, advance model, compare every output.
  task automatic tick();
    bit acc;
    logic [7:0] d;
    bit r;
    acc = tx_valid && tx_ready;
    d   = tx_data;
    r   = rst;
    @(posedge clk);
    if (acc && !r) got.push_back(d);
    model_step(r, res_valid, res_data, tx_ready);
    #1;
    chk("tx_valid", tx_valid, m_act);
    if (m_act) chk("tx_data", tx_data, m_fb[m_idx]);
    if (r) chk("tx_data_rst", tx_data, 8'h00);
    chk("busy", busy, m_act);
    chk("pending", pending, mq.size() > 0);
    chk("overflow", overflow, m_ovf);
    m_rst_prev = r;
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    res_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic strobe(input logic [3:0] v);
    res_valid = 1'b1;
    res_data  = v;
    tick();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    tx_ready = 1'b1;
    while ((busy || pending) && n < 500) begin
      tick();
      n++;
    end
    chk({nm, "_drain_timeout"}, busy || pending, 0);
  endtask

  task automatic expect_byte(input string nm, input logic [7:0] e);
    if (got.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=none required=%0h", nm, e);
    end else begin
      chk(nm, got.pop_front(), e);
    end
  endtask

  initial begin
    logic [7:0] hold;
    int nvalid_gap;
    int frames;
    int n;
    logic [7:0] fpay;
    logic [3:0] i4;

    rst = 1'b1;
    res_valid = 1'b0;
    res_data = '0;
    tx_ready = 1'b0;

    // Frame table for the sequence-wrap run: results 0..15 then 0
    for (int i = 0; i < 17; i++) begin
      i4 = 4'(i);
      fpay = {i4, i4};
      tbl[i].res  = i4;
      tbl[i].pay  = fpay;
      tbl[i].stat = 8'h00;
      tbl[i].csum = 8'hA5 ^ fpay;
    end

    // Reset state
    do_reset();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);

    // Single frame with latency check
    tx_ready = 1'b1;
    strobe(4'd6);
    chk("lat_n1_valid", tx_valid, 0);
    chk("lat_n1_pending", pending, 1);
    tick();
    chk("lat_n2_valid", tx_valid, 1);
    chk("lat_n2_hdr", tx_data, 8'hA5);
    drain("single");
    chk("single_busy_low", busy, 0);
    expect_byte("single_b0", 8'hA5);
    expect_byte("single_b1", 8'h06);
    expect_byte("single_b2", 8'h00);
    expect_byte("single_b3", 8'hA3);

    // Back-pressure: two frames queued while stalled, then back to back
    do_reset();
    tx_ready = 1'b0;
    strobe(4'd3);
    tick();
    strobe(4'd9);
    tick();
    hold = tx_data;
    for (int i = 0; i < 6; i++) tick();
    chk("stall_hold", tx_data, hold);
    chk("stall_hdr", tx_data, 8'hA5);
    tx_ready = 1'b1;
    nvalid_gap = 0;
    n = 0;
    while ((busy || pending) && n < 100) begin
      tick();
      if (busy && !tx_valid) nvalid_gap++;
      n++;
    end
    chk("bp_no_gap", nvalid_gap, 0);
    chk("bp_done", busy || pending, 0);
    expect_byte("bp_f0_b0", 8'hA5);
    expect_byte("bp_f0_b1", 8'h03);
    expect_byte("bp_f0_b2", 8'h40);
    expect_byte("bp_f0_b3", 8'hE6);
    expect_byte("bp_f1_b0", 8'hA5);
    expect_byte("bp_f1_b1", 8'h19);
    expect_byte("bp_f1_b2", 8'h00);
    expect_byte("bp_f1_b3", 8'hBC);

    // Overflow: third result dropped and reported in the first status byte
    do_reset();
    tx_ready = 1'b0;
    strobe(4'd1);
    strobe(4'd2);
    strobe(4'd3);
    tick();
    chk("ovf_flag", overflow, 1);
    drain("ovf");
    chk("ovf_cleared", overflow, 0);
    expect_byte("ovf_f0_b0", 8'hA5);
    expect_byte("ovf_f0_b1", 8'h01);
    expect_byte("ovf_f0_b2", 8'hC1);
    expect_byte("ovf_f0_b3", 8'h65);
    expect_byte("ovf_f1_b0", 8'hA5);
    expect_byte("ovf_f1_b1", 8'h12);
    expect_byte("ovf_f1_b2", 8'h00);
    expect_byte("ovf_f1_b3", 8'hB7);
    chk("ovf_no_extra", got.size(), 0);

    // Sequence wrap, table driven
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      strobe(tbl[i].res);
      drain("wrap");
      expect_byte("wrap_hdr", 8'hA5);
      expect_byte("wrap_pay", tbl[i].pay);
      expect_byte("wrap_stat", tbl[i].stat);
      expect_byte("wrap_csum", tbl[i].csum);
    end

    // Randomized strobes and tx_ready against the model
    do_reset();
    frames = 0;
    n = 0;
    while (frames < 200 && n < 30000) begin
      res_valid = ($urandom_range(0, 7) == 0);
      res_data  = 4'($urandom_range(0, 15));
      tx_ready  = $urandom_range(0, 1) == 1;
      tick();
      frames = got.size() / 4;
      n++;
    end
    drain("rand");
    chk("rand_frames_done", frames >= 200, 1);
    chk("rand_whole_frames", got.size() % 4, 0);

    // Reset in the middle of a frame, while stalled on the status byte
    do_reset();
    tx_ready = 1'b1;
    strobe(4'd7);
    n = 0;
    while (!(m_act && m_idx == 2) && n < 20) begin
      tick();
      n++;
    end
    chk("mid_reach_stat", m_act && m_idx == 2, 1);
    tx_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("mid_valid", tx_valid, 0);
    chk("mid_data", tx_data, 8'h00);
    chk("mid_busy", busy, 0);
    chk("mid_pending", pending, 0);
    chk("mid_ovf", overflow, 0);
    rst = 1'b0;
    got.delete();
    tick();
    strobe(4'd5);
    drain("mid");
    expect_byte("mid_b0", 8'hA5);
    expect_byte("mid_b1", 8'h05);
    expect_byte("mid_b2", 8'h00);
    expect_byte("mid_b3", 8'hA0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
